// File: rtl/datapath_cmd_sequencer.sv
// datapath_cmd_sequencer
//   Buffers datapath control words in a small FIFO and issues each one to the
//   register-file/ALU datapath for cmd_rep+1 consecutive clock edges. The
//   datapath status is captured at the final execution of every command, and
//   done pulses for one cycle afterwards.
//
//   Optional build macro: DPSEQ_ZERO_EXIT_EN
//     Defined   - status[ZERO_BIT]=1 at an execution edge ends the command early.
//     Undefined - status is only captured into last_status.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     command handshake; accepted when both are high
//   cmd_da/sa/sb/w/k/bs/fs    control word fields
//   cmd_rep                   extra repetitions (word executes cmd_rep+1 times)
//   da/sa/sb/w/k/bs/fs        control outputs to the datapath
//   status                    datapath status flags
//   busy                      a command is executing or the FIFO is non-empty
//   done                      one-cycle pulse after a command's final execution
//   last_status               status captured at the last completed command
module datapath_cmd_sequencer #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned REP_W    = 4,
   parameter int unsigned ZERO_BIT = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [4:0]       cmd_da,
   input  logic [4:0]       cmd_sa,
   input  logic [4:0]       cmd_sb,
   input  logic             cmd_w,
   input  logic [63:0]      cmd_k,
   input  logic             cmd_bs,
   input  logic [4:0]       cmd_fs,
   input  logic [REP_W-1:0] cmd_rep,
   output logic [4:0]       da,
   output logic [4:0]       sa,
   output logic [4:0]       sb,
   output logic             w,
   output logic [63:0]      k,
   output logic             bs,
   output logic [4:0]       fs,
   input  logic [3:0]       status,
   output logic             busy,
   output logic             done,
   output logic [3:0]       last_status
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Control word without the repeat field, then with it in the low bits.
   localparam int unsigned CUR_W  = 5 + 5 + 5 + 1 + 64 + 1 + 5;
   localparam int unsigned WORD_W = CUR_W + REP_W;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

`ifdef DPSEQ_ZERO_EXIT_EN
   localparam logic ZERO_EXIT_EN = 1'b1;
`else
   localparam logic ZERO_EXIT_EN = 1'b0;
`endif

   typedef enum logic {StIdle, StIssue} state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic [CUR_W-1:0]  cur_q;
   logic [REP_W-1:0]  rep_cnt_q;
   logic              done_q;
   logic [3:0]        last_status_q;

   logic              full, empty, push, pop, complete, cur_w;
   logic [WORD_W-1:0] head;

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   // Depends on occupancy only; held low while reset is asserted.
   assign cmd_ready = reset & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_da, cmd_sa, cmd_sb, cmd_w, cmd_k, cmd_bs, cmd_fs, cmd_rep};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sequencing FSM
   // ---------------------------------------------------------------------
   // Final execution of the current word happens at this edge.
   assign complete = (state_q == StIssue) &
                     ((rep_cnt_q == '0) | (ZERO_EXIT_EN & status[ZERO_BIT]));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty) state_d = StIssue;
         StIssue: if (complete && empty) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop = 1'b0;
      w   = 1'b0;
      unique case (state_q)
         StIdle:  pop = ~empty;
         StIssue: begin
            pop = complete & ~empty;
            w   = cur_w;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Current word, repeat counter, completion reporting
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur_q         <= '0;
         rep_cnt_q     <= '0;
         done_q        <= 1'b0;
         last_status_q <= '0;
      end else begin
         done_q <= complete;
         if (complete) last_status_q <= status;
         if (pop) begin
            cur_q     <= head[WORD_W-1:REP_W];
            rep_cnt_q <= head[REP_W-1:0];
         end else if (complete) begin
            // Early exit may leave repetitions; drop them.
            rep_cnt_q <= '0;
         end else if (state_q == StIssue) begin
            rep_cnt_q <= rep_cnt_q - REP_ONE;
         end
      end
   end

   assign {da, sa, sb, cur_w, k, bs, fs} = cur_q;
   assign busy        = (state_q == StIssue) | ~empty;
   assign done        = done_q;
   assign last_status = last_status_q;

endmodule

// File: tb/tb_datapath_cmd_sequencer.sv
// Directed testbench for datapath_cmd_sequencer (DEPTH=4, REP_W=4, ZERO_BIT=0).
module tb_datapath_cmd_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_da, cmd_sa, cmd_sb, cmd_fs;
   logic        cmd_w, cmd_bs;
   logic [63:0] cmd_k;
   logic [3:0]  cmd_rep;
   logic [4:0]  da, sa, sb, fs;
   logic        w, bs;
   logic [63:0] k;
   logic [3:0]  status;
   logic        busy, done;
   logic [3:0]  last_status;

   int checks = 0;
   int errors = 0;

   datapath_cmd_sequencer #(.DEPTH(4), .REP_W(4), .ZERO_BIT(0)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_da(cmd_da), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_w(cmd_w),
      .cmd_k(cmd_k), .cmd_bs(cmd_bs), .cmd_fs(cmd_fs), .cmd_rep(cmd_rep),
      .da(da), .sa(sa), .sb(sb), .w(w), .k(k), .bs(bs), .fs(fs),
      .status(status), .busy(busy), .done(done), .last_status(last_status)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_cmd(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                          input logic wv, input logic [63:0] kv, input logic bsv,
                          input logic [4:0] f, input logic [3:0] r);
      cmd_valid = 1'b1;
      cmd_da = d; cmd_sa = a; cmd_sb = b; cmd_w = wv;
      cmd_k = kv; cmd_bs = bsv; cmd_fs = f; cmd_rep = r;
   endtask

   task automatic test_reset;
      reset = 1'b0; cmd_valid = 1'b0; status = 4'b0000;
      set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
      cmd_valid = 1'b0;
      tick; tick;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
      checks++; if (w !== 1'b0) begin errors++; $display("FAIL rst_w: got %b want 0", w); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (last_status !== 4'h0) begin errors++; $display("FAIL rst_last_status: got %h want 0", last_status); end
      checks++; if ({da, sa, sb, fs, bs} !== 21'h0 || k !== 64'h0) begin errors++; $display("FAIL rst_ctrl: da=%0d sa=%0d sb=%0d fs=%0d bs=%b k=%0h want all 0", da, sa, sb, fs, bs, k); end
      reset = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b want 1", cmd_ready); end
   endtask

   task automatic test_single;
      set_cmd(5, 31, 0, 1, 64'd24, 1, 5'b00100, 0);
      tick; // E0 accept
      cmd_valid = 1'b0;
      checks++; if (w !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_e0: w=%b busy=%b done=%b want 0 1 0", w, busy, done); end
      tick; // E1 load
      checks++; if (w !== 1'b1) begin errors++; $display("FAIL single_w: got %b want 1", w); end
      checks++; if (da !== 5'd5 || sa !== 5'd31 || bs !== 1'b1 || k !== 64'd24 || fs !== 5'b00100) begin errors++; $display("FAIL single_ctrl: da=%0d sa=%0d bs=%b k=%0d fs=%b", da, sa, bs, k, fs); end
      tick; // E2 execute
      checks++; if (w !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_e2: w=%b done=%b busy=%b want 0 1 0", w, done, busy); end
      checks++; if (da !== 5'd5) begin errors++; $display("FAIL single_hold_da: got %0d want 5", da); end
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
   endtask

   // One long command keeps the FIFO from draining while four rep=3 words fill it.
   task automatic test_back_to_back;
      logic exp_w, exp_done, exp_ready, exp_busy;
      logic [4:0] exp_da;
      set_cmd(9, 1, 2, 1, 64'd99, 0, 5'b00001, 15);
      for (int t = 1; t <= 37; t++) begin
         tick;
         if (t + 1 >= 2 && t + 1 <= 5) set_cmd(5'(t), 3, 4, 1, 64'(t), 0, 5'b00010, 3);
         else if (t + 1 <= 19) set_cmd(5, 6, 7, 1, 64'd5, 1, 5'b00011, 0);
         else cmd_valid = 1'b0;
         exp_w     = (t >= 2 && t <= 34);
         exp_done  = (t == 18 || t == 22 || t == 26 || t == 30 || t == 34 || t == 35);
         exp_ready = !((t >= 5 && t <= 17) || (t >= 19 && t <= 21));
         exp_busy  = (t <= 34);
         if (t <= 17) exp_da = 5'd9;
         else if (t <= 33) exp_da = 5'(1 + (t - 18) / 4);
         else exp_da = 5'd5;
         checks++; if (w !== exp_w) begin errors++; $display("FAIL b2b_w t=%0d: got %b want %b", t, w, exp_w); end
         checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done t=%0d: got %b want %b", t, done, exp_done); end
         checks++; if (cmd_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready t=%0d: got %b want %b", t, cmd_ready, exp_ready); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy t=%0d: got %b want %b", t, busy, exp_busy); end
         if (exp_w) begin
            checks++; if (da !== exp_da) begin errors++; $display("FAIL b2b_da t=%0d: got %0d want %0d", t, da, exp_da); end
         end
      end
   endtask

   task automatic test_repeat;
      logic exp_w, exp_done;
      set_cmd(17, 30, 3, 1, 64'd2, 1, 5'b10000, 2);
      tick;
      cmd_valid = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         tick;
         exp_w    = (t <= 3);
         exp_done = (t == 4);
         checks++; if (w !== exp_w) begin errors++; $display("FAIL rep_w t=%0d: got %b want %b", t, w, exp_w); end
         checks++; if (done !== exp_done) begin errors++; $display("FAIL rep_done t=%0d: got %b want %b", t, done, exp_done); end
         if (exp_w) begin
            checks++; if (da !== 5'd17 || sa !== 5'd30 || sb !== 5'd3 || bs !== 1'b1 || k !== 64'd2 || fs !== 5'b10000) begin errors++; $display("FAIL rep_ctrl t=%0d: da=%0d sa=%0d sb=%0d bs=%b k=%0d fs=%b", t, da, sa, sb, bs, k, fs); end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rep_busy: got %b want 0", busy); end
   endtask

   task automatic test_status;
      set_cmd(7, 1, 1, 0, 64'd0, 0, 5'b00000, 1);
      tick; // E0
      cmd_valid = 1'b0;
      tick; // E1 load
      status = 4'b0100;
      tick; // E2 first execution
      checks++; if (done !== 1'b0 || last_status !== 4'b0000) begin errors++; $display("FAIL stat_mid: done=%b last_status=%b want 0 0000", done, last_status); end
      status = 4'b1010;
      tick; // E3 final execution
      checks++; if (last_status !== 4'b1010) begin errors++; $display("FAIL stat_capture: got %b want 1010", last_status); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL stat_done: got %b want 1", done); end
      status = 4'b1111;
      tick; tick;
      checks++; if (last_status !== 4'b1010) begin errors++; $display("FAIL stat_hold: got %b want 1010", last_status); end
      status = 4'b0000;
   endtask

   task automatic test_zero_exit;
      logic exp_w, exp_done;
      logic [4:0] exp_da;
      set_cmd(11, 2, 2, 1, 64'd7, 1, 5'b00101, 7);
      tick; // E0 push A
      set_cmd(12, 3, 3, 1, 64'd8, 0, 5'b00110, 0);
      tick; // E1 push B, load A
      cmd_valid = 1'b0;
      for (int t = 2; t <= 12; t++) begin
         status = (t == 4) ? 4'b0001 : 4'b0000;
         tick;
`ifdef DPSEQ_ZERO_EXIT_EN
         exp_w    = (t <= 4);
         exp_done = (t == 4 || t == 5);
         exp_da   = (t <= 3) ? 5'd11 : 5'd12;
         if (t == 4) begin
            checks++; if (last_status !== 4'b0001) begin errors++; $display("FAIL zx_last_status: got %b want 0001", last_status); end
         end
`else
         exp_w    = (t <= 9);
         exp_done = (t == 9 || t == 10);
         exp_da   = (t <= 8) ? 5'd11 : 5'd12;
         if (t == 4) begin
            checks++; if (last_status !== 4'b1010) begin errors++; $display("FAIL zx_last_status: got %b want 1010", last_status); end
         end
`endif
         checks++; if (w !== exp_w) begin errors++; $display("FAIL zx_w t=%0d: got %b want %b", t, w, exp_w); end
         checks++; if (done !== exp_done) begin errors++; $display("FAIL zx_done t=%0d: got %b want %b", t, done, exp_done); end
         if (exp_w) begin
            checks++; if (da !== exp_da) begin errors++; $display("FAIL zx_da t=%0d: got %0d want %0d", t, da, exp_da); end
         end
      end
      status = 4'b0000;
   endtask

   task automatic test_reset_mid;
      set_cmd(20, 1, 1, 1, 64'd1, 0, 5'b00001, 3);
      tick; // E0 push A
      set_cmd(21, 1, 1, 1, 64'd1, 0, 5'b00001, 0);
      tick; // E1 push B, load A
      set_cmd(22, 1, 1, 1, 64'd1, 0, 5'b00001, 0);
      tick; // E2 push C, first execution of A
      cmd_valid = 1'b0;
      checks++; if (w !== 1'b1 || da !== 5'd20) begin errors++; $display("FAIL mid_pre: w=%b da=%0d want 1 20", w, da); end
      #2 reset = 1'b0;
      #1;
      checks++; if (w !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: w=%b busy=%b want 0 0", w, busy); end
      checks++; if (cmd_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_ready_done: ready=%b done=%b want 0 0", cmd_ready, done); end
      checks++; if (da !== 5'd0 || last_status !== 4'h0) begin errors++; $display("FAIL mid_clear: da=%0d last_status=%b want 0 0000", da, last_status); end
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", done); end
      reset = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_release: ready=%b busy=%b want 1 0", cmd_ready, busy); end
      for (int t = 1; t <= 5; t++) begin
         tick;
         checks++; if (w !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_empty t=%0d: w=%b done=%b busy=%b want 0 0 0", t, w, done, busy); end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_repeat;
      test_status;
      test_zero_exit;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_cmd_sequencer.md
Name: datapath_cmd_sequencer

Overview:
Command sequencer in front of the register-file/ALU datapath.
- Buffers datapath control words (DA, SA, SB, W, K, BS, FS plus a repeat count) from a requester in a small FIFO.
- Issues them to the datapath one execution per clock, repeating each word a programmed number of times.
- Captures the datapath status at the final execution of each command and reports completion.
- Sits between the controller or testbench driver and the datapath's control inputs.

Parameters:
DEPTH, 4, command FIFO depth; power of 2, at least 2
REP_W, 4, width of the repeat-count field
ZERO_BIT, 0, index of the Zero flag within status[3:0]

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  requester presents a command
cmd_ready  out  1  sequencer can accept a command
cmd_da  in  5  destination register
cmd_sa  in  5  source A register
cmd_sb  in  5  source B register
cmd_w  in  1  register write enable for this command
cmd_k  in  64  immediate constant
cmd_bs  in  1  B-select (1 = K, 0 = register B)
cmd_fs  in  5  ALU function select
cmd_rep  in  REP_W  extra repetitions; the word executes cmd_rep+1 times
da  out  5  to datapath DA
sa  out  5  to datapath SA
sb  out  5  to datapath SB
w  out  1  to datapath W
k  out  64  to datapath K
bs  out  1  to datapath BS
fs  out  5  to datapath FS
status  in  4  datapath status flags
busy  out  1  a command is executing or the FIFO is non-empty
done  out  1  one-cycle pulse when a command completes
last_status  out  4  status sampled at the final execution of the last completed command

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO emptied; state IDLE; repeat counter 0.
  - Outputs: cmd_ready=0 while reset is asserted, then 1; w=0; da/sa/sb/fs=0, k=0, bs=0; busy=0; done=0; last_status=0.
  - A reset asserted mid-command aborts it with no done pulse, and w drops immediately.
- FIFO and handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = !full; it depends on FIFO count only, never on a same-cycle pop.
  - When full, cmd_ready=0 and cmd_valid is ignored, even if a pop occurs that edge.
  - Push and pop on the same edge (not full) is legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - Outputs hold their last values; w=0.
    - If the FIFO is non-empty at an edge: pop head into the current-word register, load counter = cmd_rep, go to ISSUE.
  - ISSUE:
    - Outputs drive the current word; w = current cmd_w.
    - Each rising edge in ISSUE is one datapath execution.
    - If counter != 0: decrement and stay in ISSUE.
    - If counter == 0:
      - The command is complete; last_status <= status sampled at this edge.
      - done=1 for the following cycle.
      - If the FIFO is non-empty: pop the next command and stay in ISSUE, with no bubble.
      - Otherwise go to IDLE.
- Latency:
  - Command accepted at edge E0 into an empty, idle sequencer: loaded at E1, first execution at E2.
  - Final execution at edge E2+cmd_rep; done high in the cycle after it.
  - Back-to-back commands execute on consecutive edges.
- cmd_rep = 0 executes exactly once; cmd_rep = 2^REP_W-1 executes 2^REP_W times. The counter never underflows.
- busy = (state==ISSUE) | !empty.

Optional Feature:
DPSEQ_ZERO_EXIT_EN
- Defined: in ISSUE, if status[ZERO_BIT]=1 at an execution edge with counter != 0, the command completes at that edge.
  - last_status is captured, done pulses, and the next command is popped as in normal completion.
  - Remaining repetitions are discarded.
- Undefined: status is only sampled into last_status and never affects sequencing.

Test Plan:
- Reset then a single push {da=5, sa=31, bs=1, k=24, fs=00100, w=1, rep=0} -> w=1 with da=5 only between E1 and E2; done pulses once after E2; busy falls after that.
- Push four commands back-to-back with no pop possible (all rep=3) -> cmd_ready=0 after the 4th accept; a 5th cmd_valid is not accepted until the first pop; executions are contiguous, with 4 done pulses spaced 4 cycles apart.
- Command {da=17, sa=30, bs=1, k=2, fs=10000, rep=2} -> exactly 3 consecutive edges with w=1 and identical control outputs; counter reaches 0 with no underflow; one done pulse.
- Assert reset during the 2nd of rep=3 executions, with 2 commands queued -> w=0 and busy=0 immediately, no done pulse, FIFO empty, cmd_ready=1 after release.
- With status forced to 4'b1010 at the final execution edge -> last_status=4'b1010, held until the next completion.
- With DPSEQ_ZERO_EXIT_EN defined, rep=7 and status[ZERO_BIT] rising at the 3rd execution -> done after the 3rd edge, next command issued on the following edge. Undefined: 8 executions regardless of status.
